alu_arbiter: RTL and testbench

//  Shares one combinational 8-bit ALU (eight_bit_alu) between two requesters.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 27 ++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the ALU arbiter slice: the opcode map of the
//   external eight_bit_alu, the arbiter FSM state encoding and a small
//   helper that turns a requester index into a one-hot vector.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Opcode map of eight_bit_alu (ALU_Sel values)
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_ASQ = 4'd6;
    localparam logic [3:0] OP_BSQ = 4'd7;

    // Arbiter FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Requester index -> one-hot request/response vector
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant, purely combinational. The register holding
//   the previous winner lives in the parent.
// Ports
//   req_valid  in  [1:0]  requests currently presented
//   last_grant in         index of the requester granted most recently
//   grant      out [1:0]  one-hot grant, all zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone request is already one-hot; only a tie needs the history bit,
    // and then the requester that did not win last time goes first.
    always_comb begin
        grant = req_valid;
        if (&req_valid) begin
            grant = onehot2(~last_grant);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational 8-bit ALU between two requesters. A request is
//   accepted in IDLE, the ALU is driven for exactly one EXEC cycle, and the
//   registered result is held in RESP until the owner takes it. Illegal
//   opcodes and divide-by-zero never fire the ALU and return err=1.
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  per-requester request handshake
//   req_a/req_b/req_op   packed payloads, requester n at [n*W +: W]
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_data/carry/err   shared response payload
//   alu_a/b/sel/latch    drive the external ALU (zero outside EXEC)
//   alu_out/alu_carry    result returned by the external ALU
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4,
    parameter int NUM_OPS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [2*OP_W-1:0]     req_op,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OP_W-1:0]       alu_sel,
    output logic                  alu_latch,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_carry
);

    localparam logic [OP_W:0] NUM_OPS_V = (OP_W+1)'(NUM_OPS);

    state_t              state;
    logic                last_grant;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [OP_W-1:0]     op_reg;
    logic [1:0]          grant;
    logic                grant_idx;
    logic                op_err;

    rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign grant_idx = grant[1];

    // last_grant doubles as the owner of the transaction in flight, since
    // it is updated on the same handshake that starts the transaction.
    assign req_ready = (state == ST_IDLE && !reset) ? grant : 2'b00;
    assign rsp_valid = (state == ST_RESP) ? onehot2(last_grant) : 2'b00;

    // Rejected operations: opcode outside the ALU's table, or DIV by zero.
    assign op_err = ({1'b0, op_reg} >= NUM_OPS_V) ||
                    (op_reg == OP_W'(OP_DIV) && b_reg == '0);

    // The ALU sees operands only during EXEC so it idles at zero otherwise.
    assign alu_a     = (state == ST_EXEC) ? a_reg  : '0;
    assign alu_b     = (state == ST_EXEC) ? b_reg  : '0;
    assign alu_sel   = (state == ST_EXEC) ? op_reg : '0;
    assign alu_latch = (state == ST_EXEC) && !op_err;

    // Transaction FSM: capture payload on acceptance, sample the ALU at the
    // end of EXEC, then hold the response until its owner is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        a_reg      <= grant_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                        b_reg      <= grant_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                        op_reg     <= grant_idx ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
                        last_grant <= grant_idx;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_err) begin
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b1;
                    end else begin
                        rsp_data  <= alu_out;
                        rsp_carry <= alu_carry;
                        rsp_err   <= 1'b0;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[last_grant]) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. A behavioural eight_bit_alu sits on
//   the ALU port; for rejected operations it returns junk so the arbiter has
//   to zero the response itself. Expected responses are queued per requester
//   and checked when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 4;
    localparam int NUM_OPS = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } stim_t;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic       err;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [2*OP_W-1:0]   req_op;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_carry;
    logic                rsp_err;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [OP_W-1:0]     alu_sel;
    logic                alu_latch;
    logic [DATA_W-1:0]   alu_out;
    logic                alu_carry;

    stim_t stim_q0[$];
    stim_t stim_q1[$];
    exp_t  exp_q0[$];
    exp_t  exp_q1[$];
    int    grant_log[$];

    int vectors     = 0;
    int miscompares = 0;
    int latch_cnt   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .DATA_W  (DATA_W),
        .OP_W    (OP_W),
        .NUM_OPS (NUM_OPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_latch (alu_latch),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    // Behavioural eight_bit_alu: 9-bit result, bit 8 is CarryOut
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
        logic [15:0] p;
        case (sel)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {1'b0, a} - {1'b0, b};
            4'd2: begin p = a * b; return p[8:0]; end
            4'd3: return (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
            4'd4: return {a, 1'b0};
            4'd5: return {1'b0, a >> 1};
            4'd6: begin p = a * a; return p[8:0]; end
            4'd7: begin p = b * b; return p[8:0]; end
            default: return 9'h1AA;
        endcase
    endfunction

    // Expected arbiter response for one request
    function automatic exp_t ref_rsp(input stim_t s);
        exp_t       e;
        logic [8:0] r;
        if (s.op >= 4'd8 || (s.op == 4'd3 && s.b == 8'd0)) begin
            e.data = 8'd0; e.carry = 1'b0; e.err = 1'b1;
        end else begin
            r = alu_model(s.a, s.b, s.op);
            e.data = r[7:0]; e.carry = r[8]; e.err = 1'b0;
        end
        return e;
    endfunction

    always_comb begin
        {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);
    end

    task automatic drive_payload(input int n, input stim_t s);
        req_a[n*DATA_W +: DATA_W] = s.a;
        req_b[n*DATA_W +: DATA_W] = s.b;
        req_op[n*OP_W +: OP_W]    = s.op;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        stim_q0.delete(); stim_q1.delete();
        exp_q0.delete();  exp_q1.delete();
    endtask

    // Presents queued stimulus on both requesters, records grants, counts
    // ALU fires and checks every response against the scoreboard.
    // Called and returns one time unit after a rising edge.
    task automatic run_txns(input int want, input int budget);
        int         done;
        int         cycles;
        logic [1:0] hs;
        exp_t       e;
        done   = 0;
        cycles = 0;
        while (done < want && cycles < budget) begin
            req_valid[0] = (stim_q0.size() > 0);
            req_valid[1] = (stim_q1.size() > 0);
            if (stim_q0.size() > 0) drive_payload(0, stim_q0[0]);
            if (stim_q1.size() > 0) drive_payload(1, stim_q1[0]);
            @(negedge clk);
            hs = req_valid & req_ready;
            if (alu_latch) latch_cnt++;
            vectors++;
            if (rsp_valid === 2'b11) begin
                miscompares++;
                $display("[TB] FAIL rsp_onehot: rsp_valid=%b required one-hot", rsp_valid);
            end
            for (int n = 0; n < 2; n++) begin
                if (rsp_valid[n] && rsp_ready[n]) begin
                    vectors++;
                    if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
                        miscompares++;
                        $display("[TB] FAIL rsp_unexpected: requester %0d data=%h with nothing outstanding",
                                 n, rsp_data);
                    end else begin
                        e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if ({rsp_data, rsp_carry, rsp_err} !== {e.data, e.carry, e.err}) begin
                            miscompares++;
                            $display("[TB] FAIL rsp_req%0d: got data=%h carry=%b err=%b, required data=%h carry=%b err=%b",
                                     n, rsp_data, rsp_carry, rsp_err, e.data, e.carry, e.err);
                        end
                    end
                    done++;
                end
            end
            @(posedge clk);
            #1;
            if (hs[0]) begin
                exp_q0.push_back(ref_rsp(stim_q0[0]));
                void'(stim_q0.pop_front());
                grant_log.push_back(0);
            end
            if (hs[1]) begin
                exp_q1.push_back(ref_rsp(stim_q1[0]));
                void'(stim_q1.pop_front());
                grant_log.push_back(1);
            end
            cycles++;
        end
        req_valid = 2'b00;
        if (done < want) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL txn_timeout: %0d responses seen, %0d required", done, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, alu_a, alu_b, alu_sel, alu_latch} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got rsp_valid=%b data=%h err=%b alu_a=%h latch=%b, required all 0",
                     rsp_valid, rsp_data, rsp_err, alu_a, alu_latch);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, alu_a, alu_b, alu_sel, alu_latch} !== '0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got req_ready=%b rsp_valid=%b latch=%b, required all 0",
                     req_ready, rsp_valid, alu_latch);
        end
        @(posedge clk);
        #1;
    endtask

    // req0 ADD 200+100 = 300 -> data 44, carry 1
    task automatic test_single();
        int k;
        req_valid = 2'b01;
        drive_payload(0, '{a: 8'd200, b: 8'd100, op: OP_ADD});
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL single_ready: got %b required 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        vectors++;
        if ({alu_latch, alu_a, alu_b, alu_sel, rsp_valid} !== {1'b1, 8'd200, 8'd100, 4'd0, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL single_exec: got latch=%b a=%0d b=%0d sel=%0d rsp_valid=%b, required 1 200 100 0 00",
                     alu_latch, alu_a, alu_b, alu_sel, rsp_valid);
        end
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) break;
        end
        vectors++;
        if ({rsp_valid, rsp_data, rsp_carry, rsp_err, alu_latch} !== {2'b01, 8'd44, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL single_rsp: got valid=%b data=%0d carry=%b err=%b latch=%b, required 01 44 1 0 0",
                     rsp_valid, rsp_data, rsp_carry, rsp_err, alu_latch);
        end
        @(posedge clk);
        #1 rsp_ready = 2'b01;
        @(posedge clk);
        #1 rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_release: rsp_valid=%b required 00", rsp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tie();
        do_reset();
        rsp_ready = 2'b11;
        grant_log.delete();
        stim_q0.push_back('{a: 8'd12, b: 8'd10, op: OP_MUL});
        stim_q1.push_back('{a: 8'd5,  b: 8'd9,  op: OP_SUB});
        run_txns(2, 40);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            miscompares++;
            $display("[TB] FAIL tie_order: got %0d grants, first=%0d, required 2 grants order 0,1",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
        grant_log.delete();
        stim_q0.push_back('{a: 8'd1, b: 8'd2, op: OP_ADD});
        stim_q1.push_back('{a: 8'd3, b: 8'd4, op: OP_ADD});
        run_txns(2, 40);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0) begin
            miscompares++;
            $display("[TB] FAIL tie_again: got first=%0d required 0",
                     (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    // DIV by zero and opcodes 8 and 9 are rejected; a legal DIV still fires
    task automatic test_errors();
        rsp_ready = 2'b11;
        latch_cnt = 0;
        stim_q1.push_back('{a: 8'd50, b: 8'd0, op: OP_DIV});
        stim_q1.push_back('{a: 8'd50, b: 8'd7, op: 4'd9});
        stim_q1.push_back('{a: 8'd50, b: 8'd7, op: 4'd8});
        stim_q0.push_back('{a: 8'd50, b: 8'd5, op: OP_DIV});
        run_txns(4, 60);
        vectors++;
        if (latch_cnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL err_latch: alu_latch fired %0d times, required 1", latch_cnt);
        end
    endtask

    task automatic test_backpressure();
        int    k;
        stim_t s0;
        stim_t s1;
        exp_t  e;
        s0 = '{a: 8'd0, b: 8'd20, op: OP_BSQ};
        s1 = '{a: 8'd7, b: 8'd3,  op: OP_ADD};
        e  = ref_rsp(s0);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        drive_payload(0, s0);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0]) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        drive_payload(1, s1);
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) break;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_data, rsp_carry, rsp_err, req_ready} !== {2'b01, e.data, e.carry, e.err, 2'b00}) begin
                miscompares++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b data=%h carry=%b err=%b ready=%b, required 01 %h %b %b 00",
                         i, rsp_valid, rsp_data, rsp_carry, rsp_err, req_ready, e.data, e.carry, e.err);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 2'b01;
        @(posedge clk);
        #1 rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== {2'b00, 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL release_idle: got rsp_valid=%b req_ready=%b, required 00 10", rsp_valid, req_ready);
        end
        exp_q1.push_back(ref_rsp(s1));
        @(posedge clk);
        #1 req_valid = 2'b00;
        rsp_ready = 2'b11;
        run_txns(1, 20);
    endtask

    task automatic test_reset_mid();
        int   k;
        logic seen;
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        drive_payload(0, '{a: 8'h81, b: 8'd0, op: OP_SHL});
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0]) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({alu_latch, alu_a} !== {1'b1, 8'h81}) begin
            miscompares++;
            $display("[TB] FAIL mid_exec: got latch=%b a=%h, required 1 81", alu_latch, alu_a);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, alu_a, alu_b, alu_sel, alu_latch} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_outputs: got rsp_valid=%b data=%h latch=%b a=%h, required all 0",
                     rsp_valid, rsp_data, alu_latch, alu_a);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_no_rsp: dropped transaction produced rsp_valid (seen=%b), required 0", seen);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        grant_log.delete();
        stim_q0.push_back('{a: 8'h81, b: 8'd0, op: OP_SHL});
        stim_q1.push_back('{a: 8'd1,  b: 8'd1, op: OP_ADD});
        run_txns(2, 40);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0) begin
            miscompares++;
            $display("[TB] FAIL mid_restart_grant: got first=%0d required 0",
                     (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        int    legal;
        rsp_ready = 2'b11;
        latch_cnt = 0;
        legal     = 0;
        grant_log.delete();
        for (int i = 0; i < 10; i++) begin
            for (int n = 0; n < 2; n++) begin
                s.a  = 8'($urandom_range(0, 255));
                s.b  = (i == 3) ? 8'd0 : 8'($urandom_range(0, 255));
                s.op = 4'($urandom_range(0, 8));
                if (!ref_rsp(s).err) legal++;
                if (n == 0) stim_q0.push_back(s);
                else        stim_q1.push_back(s);
            end
        end
        run_txns(20, 300);
        vectors++;
        if (grant_log.size() != 20) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d grants required 20", grant_log.size());
        end
        for (int i = 1; i < grant_log.size(); i++) begin
            vectors++;
            if (grant_log[i] == grant_log[i-1]) begin
                miscompares++;
                $display("[TB] FAIL b2b_alternate%0d: got %0d after %0d, required the other requester",
                         i, grant_log[i], grant_log[i-1]);
            end
        end
        vectors++;
        if (latch_cnt != legal) begin
            miscompares++;
            $display("[TB] FAIL b2b_latch: alu_latch fired %0d times, required %0d", latch_cnt, legal);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
